// File: rtl/rr_arb_pkg.sv
// Shared types and sizes for the round-robin decoder arbiter.
// Holds N_REQ/IDX_W, the FSM state enum and the search-result struct.
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

endpackage

// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between requesting agents and the arbiter.
// master: agent side (drives req); slave: arbiter side (drives grant).
interface rr_decoder_arbiter_if;
  import rr_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );

endinterface

// File: rtl/decoder.sv
// Existing 3-to-8 one-hot decoder.
// Ports: sel (3-bit index) in, dec (8-bit one-hot) out.
module decoder
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0] sel,
  output logic [N_REQ-1:0] dec
);

  always_comb begin
    dec = '0;
    dec[sel] = 1'b1;
  end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for 8 requesters; registered owner index decoded to one-hot gnt.
// Ports: clk, rst (sync, active-high), bus (slave: req in; gnt/gnt_idx/gnt_valid/timeout out).
// Optional hold timeout with masking is built when RR_ARB_TIMEOUT_EN is defined.
module rr_decoder_arbiter
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_decoder_arbiter_if.slave  bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD out of range 2..255");
  end

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic [N_REQ-1:0] own;
  logic [N_REQ-1:0] mask_eff;
  logic [N_REQ-1:0] elig;
  logic             rel;
  logic             rev;
  pick_t            win;

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0] mask_q, mask_d;
  logic             timeout_q, timeout_d;
  assign mask_eff    = mask_q;
  assign bus.timeout = timeout_q;
`else
  assign mask_eff    = '0;
  assign bus.timeout = 1'b0;
`endif

  // First eligible bit at or above ptr, wrapping 7->0.
  function automatic pick_t rr_pick(
    input logic [N_REQ-1:0] e,
    input logic [IDX_W-1:0] ptr
  );
    pick_t            r;
    logic [IDX_W-1:0] j;
    r = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = ptr + IDX_W'(i);
      if (!r.found && e[j]) begin
        r.found = 1'b1;
        r.idx   = j;
      end
    end
    return r;
  endfunction

  decoder u_dec (
    .sel (idx_q),
    .dec (own)
  );

  assign bus.gnt       = own & {N_REQ{valid_q}};
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;

  assign elig = bus.req & ~mask_eff;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    rel     = 1'b0;
    rev     = 1'b0;
    win     = '0;
`ifdef RR_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    mask_d    = mask_q & bus.req;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        win = rr_pick(elig, ptr_q);
        if (win.found) begin
          state_d = GRANT;
          idx_d   = win.idx;
          valid_d = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        rel = !bus.req[idx_q];
`ifdef RR_ARB_TIMEOUT_EN
        rev = !rel && (cnt_q == HOLD_LAST);
`endif
        if (rel || rev) begin
          ptr_d = idx_q + 1'b1;
          // Releasing/revoked owner never re-wins in the same cycle.
          win   = rr_pick(elig & ~own, ptr_d);
`ifdef RR_ARB_TIMEOUT_EN
          cnt_d     = '0;
          timeout_d = rev;
          if (rev) mask_d = mask_d | own;
`endif
          if (win.found) begin
            idx_d = win.idx;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ptr_q     <= '0;
      valid_q   <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
`ifdef RR_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Scoreboard bench for rr_decoder_arbiter (MAX_HOLD=4).
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_rr_decoder_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rr_decoder_arbiter_if bus();

  rr_decoder_arbiter #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       v;
    logic       to;
    logic       ci;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    check("onehot0", 8'($onehot0(bus.gnt)), 8'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("gnt", bus.gnt, e.gnt);
      check("gnt_valid", 8'(bus.gnt_valid), 8'(e.v));
      check("timeout", 8'(bus.timeout), 8'(e.to));
      if (e.ci) check("gnt_idx", 8'(bus.gnt_idx), 8'(e.idx));
    end
  end

  task automatic cyc(input logic [7:0] r, input logic rs,
                     input logic [7:0] g, input logic [2:0] i,
                     input logic v, input logic to);
    exp_t e;
    bus.req = r;
    rst     = rs;
    e.gnt = g;
    e.idx = i;
    e.v   = v;
    e.to  = to;
    e.ci  = v | rs;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    bus.req = 8'hFF;
    // reset with all requests pending
    cyc(8'hFF, 1, 8'h00, 3'd0, 0, 0);
    cyc(8'hFF, 1, 8'h00, 3'd0, 0, 0);
    cyc(8'hFF, 0, 8'h01, 3'd0, 1, 0);
    cyc(8'hFF, 0, 8'h01, 3'd0, 1, 0);
    // owner 0 with req 05, release chain to IDLE
    cyc(8'h05, 0, 8'h01, 3'd0, 1, 0);
    cyc(8'h04, 0, 8'h04, 3'd2, 1, 0);
    cyc(8'h00, 0, 8'h00, 3'd0, 0, 0);
    // wrap-around 7 -> 0
    cyc(8'h80, 0, 8'h80, 3'd7, 1, 0);
    cyc(8'h81, 0, 8'h80, 3'd7, 1, 0);
    cyc(8'h01, 0, 8'h01, 3'd0, 1, 0);
    cyc(8'h00, 0, 8'h00, 3'd0, 0, 0);
    // full rotation, each owner holds 2 cycles
    cyc(8'hFF, 1, 8'h00, 3'd0, 0, 0);
    cyc(8'hFF, 0, 8'h01, 3'd0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] b, nb, rq;
      b  = 8'h01 << k;
      nb = 8'h01 << ((k + 1) % 8);
      rq = 8'hFF & ~b;
      cyc(8'hFF, 0, b, 3'(k), 1, 0);
      cyc(rq, 0, nb, 3'((k + 1) % 8), 1, 0);
    end
    // hold timeout
    cyc(8'h03, 1, 8'h00, 3'd0, 0, 0);
    cyc(8'h03, 0, 8'h01, 3'd0, 1, 0);
`ifdef RR_ARB_TIMEOUT_EN
    cyc(8'h03, 0, 8'h01, 3'd0, 1, 0);
    cyc(8'h03, 0, 8'h01, 3'd0, 1, 0);
    cyc(8'h03, 0, 8'h01, 3'd0, 1, 0);
    cyc(8'h03, 0, 8'h02, 3'd1, 1, 1);
    cyc(8'h03, 0, 8'h02, 3'd1, 1, 0);
    cyc(8'h03, 0, 8'h02, 3'd1, 1, 0);
    cyc(8'h03, 0, 8'h02, 3'd1, 1, 0);
    cyc(8'h03, 0, 8'h00, 3'd0, 0, 1);
    cyc(8'h03, 0, 8'h00, 3'd0, 0, 0);
    cyc(8'h03, 0, 8'h00, 3'd0, 0, 0);
    cyc(8'h00, 0, 8'h00, 3'd0, 0, 0);
    cyc(8'h01, 0, 8'h01, 3'd0, 1, 0);
`else
    for (int k = 0; k < 8; k++) cyc(8'h03, 0, 8'h01, 3'd0, 1, 0);
`endif
    // reset mid-grant with owner 4
    cyc(8'h00, 1, 8'h00, 3'd0, 0, 0);
    cyc(8'h10, 0, 8'h10, 3'd4, 1, 0);
    cyc(8'h10, 0, 8'h10, 3'd4, 1, 0);
    cyc(8'h1C, 1, 8'h00, 3'd0, 0, 0);
    cyc(8'h1C, 0, 8'h04, 3'd2, 1, 0);
    cyc(8'h1C, 0, 8'h04, 3'd2, 1, 0);
    #1;
    check("sb_drained", 8'(sb.size()), 8'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
